// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and constants for the simon memory game
package simon_pkg;
  localparam int MEM_DEPTH_DEF = 64;
  localparam int PAT_W_DEF     = 4;

  typedef enum logic [1:0] {
    ST_INPUT    = 2'd0,
    ST_PLAYBACK = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    IDX_HOLD = 2'd0,
    IDX_CLR  = 2'd1,
    IDX_INC  = 2'd2
  } idx_op_e;

  localparam logic [2:0] MODE_INPUT    = 3'b001;
  localparam logic [2:0] MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] MODE_REPEAT   = 3'b100;
  localparam logic [2:0] MODE_DONE     = 3'b111;
endpackage

// File: rtl/simon_dpath.sv
// rtl/simon_dpath.sv - sequence length, playback index and sequence memory
module simon_dpath
  import simon_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int PAT_W     = PAT_W_DEF,
  parameter int NW        = $clog2(MEM_DEPTH + 1),
  parameter int IW        = $clog2(MEM_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [PAT_W-1:0] wdata_i,
  input  idx_op_e          idx_op_i,
  output logic [PAT_W-1:0] rdata_o,
  output logic             last_o,
  output logic             full_o
);
  logic [NW-1:0] n_q, n_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          we;

  // full gates the write so nothing ever lands past the last slot
  assign full_o = (n_q == NW'(MEM_DEPTH));
  assign last_o = (NW'(idx_q) == n_q - NW'(1));
  assign we     = wr_en_i && !full_o;

  always_comb begin
    n_d   = n_q;
    idx_d = idx_q;
    if (we) n_d = n_q + NW'(1);
    case (idx_op_i)
      IDX_CLR: idx_d = '0;
      IDX_INC: idx_d = idx_q + IW'(1);
      default: idx_d = idx_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_q   <= '0;
      idx_q <= '0;
    end else begin
      n_q   <= n_d;
      idx_q <= idx_d;
    end
  end

  simon_memory #(.DEPTH(MEM_DEPTH), .W(PAT_W)) mem (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (n_q[IW-1:0]),
    .wdata_i (wdata_i),
    .raddr_i (idx_q),
    .rdata_o (rdata_o)
  );
endmodule

// File: rtl/simon_memory.sv
// rtl/simon_memory.sv - sequence store, synchronous write, asynchronous read
module simon_memory #(
  parameter int DEPTH = 64,
  parameter int W     = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/simon.sv
// rtl/simon.sv - simon game top: control FSM plus datapath
module simon
  import simon_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int PAT_W     = PAT_W_DEF
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             sysclk,
  input  logic             level,
  input  logic [PAT_W-1:0] pattern,
  output logic [PAT_W-1:0] pattern_leds,
  output logic [2:0]       mode_leds
);
  state_e           state_q, state_d;
  idx_op_e          idx_op;
  logic             wr_en, last, full, valid;
  logic [PAT_W-1:0] rdata;
  logic             unused_sysclk;

  assign unused_sysclk = sysclk;
  assign valid = level ? ($countones(pattern) == 1) : 1'b1;

  always_ff @(posedge pclk) begin
    if (rst) state_q <= ST_INPUT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    idx_op  = IDX_HOLD;
    case (state_q)
      ST_INPUT: begin
        if (valid) begin
          wr_en   = 1'b1;
          idx_op  = IDX_CLR;
          state_d = ST_PLAYBACK;
        end
      end
      ST_PLAYBACK: begin
        if (last) begin
          idx_op  = IDX_CLR;
          state_d = ST_REPEAT;
        end else begin
          idx_op = IDX_INC;
        end
      end
      ST_REPEAT: begin
        if (pattern != rdata) begin
          idx_op  = IDX_CLR;
          state_d = ST_DONE;
        end else if (last) begin
          idx_op  = IDX_CLR;
          state_d = full ? ST_DONE : ST_INPUT;
        end else begin
          idx_op = IDX_INC;
        end
      end
      default: idx_op = last ? IDX_CLR : IDX_INC;
    endcase
  end

  always_comb begin
    mode_leds    = MODE_INPUT;
    pattern_leds = pattern;
    case (state_q)
      ST_PLAYBACK: begin mode_leds = MODE_PLAYBACK; pattern_leds = rdata; end
      ST_REPEAT:   mode_leds = MODE_REPEAT;
      ST_DONE:     begin mode_leds = MODE_DONE; pattern_leds = rdata; end
      default:     mode_leds = MODE_INPUT;
    endcase
  end

  simon_dpath #(.MEM_DEPTH(MEM_DEPTH), .PAT_W(PAT_W)) dpath (
    .clk_i    (pclk),
    .rst_i    (rst),
    .wr_en_i  (wr_en),
    .wdata_i  (pattern),
    .idx_op_i (idx_op),
    .rdata_o  (rdata),
    .last_o   (last),
    .full_o   (full)
  );
endmodule

// File: tb/tb_simon.sv
// tb/tb_simon.sv - self-checking bench for simon against a queue-based game model
module tb_simon;
  logic       pclk = 0, sysclk = 0, rst = 0, level = 0;
  logic [3:0] pattern = 0;
  logic [3:0] pattern_leds;
  logic [2:0] mode_leds;
  int n_checks = 0, n_fail = 0;

  logic [2:0] m_mode;
  logic [3:0] seq[$];
  int         pos;

  simon dut (
    .pclk         (pclk),
    .rst          (rst),
    .sysclk       (sysclk),
    .level        (level),
    .pattern      (pattern),
    .pattern_leds (pattern_leds),
    .mode_leds    (mode_leds)
  );

  always #5 pclk = ~pclk;
  always #7 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // game rules applied to the inputs present just before a clock edge
  function automatic void model_edge(input logic r, input logic lv, input logic [3:0] p);
    if (r) begin
      m_mode = 3'b001; seq.delete(); pos = 0;
      return;
    end
    case (m_mode)
      3'b001: if (!lv || $countones(p) == 1) begin
        seq.push_back(p); pos = 0; m_mode = 3'b010;
      end
      3'b010: if (pos == seq.size() - 1) begin pos = 0; m_mode = 3'b100; end
              else pos++;
      3'b100: if (p != seq[pos]) begin pos = 0; m_mode = 3'b111; end
              else if (pos == seq.size() - 1) begin
                pos = 0; m_mode = (seq.size() == 64) ? 3'b111 : 3'b001;
              end else pos++;
      default: pos = (pos == seq.size() - 1) ? 0 : pos + 1;
    endcase
  endfunction

  function automatic logic [3:0] exp_leds();
    if (m_mode == 3'b001 || m_mode == 3'b100) return pattern;
    return seq[pos];
  endfunction

  task automatic tick(input string tag);
    model_edge(rst, level, pattern);
    @(posedge pclk); #1;
    check({tag, ":mode"}, {4'b0, mode_leds}, {4'b0, m_mode});
    check({tag, ":leds"}, {3'b0, pattern_leds}, {3'b0, exp_leds()});
  endtask

  task automatic do_reset();
    rst = 1; tick("reset"); rst = 0;
  endtask

  initial begin
    logic [3:0] p;
    int done_cnt;
    m_mode = 3'b001; pos = 0;
    #1;

    // reset state and first entry / playback / repeat
    do_reset();
    check("reset_n", {dut.dpath.n_q}, 7'd0);
    pattern = 4'b0001; #1;
    check("reset_leds_live", {3'b0, pattern_leds}, 7'b0000001);
    tick("enter1");
    check("enter1_leds", {3'b0, pattern_leds}, 7'b0000001);
    tick("play1");
    check("to_repeat", {4'b0, mode_leds}, 7'b0000100);

    // correct guess, hard-mode reject, hard-mode accept
    pattern = 4'b0001; tick("guess1");
    level = 1; pattern = 4'b1010; tick("hard_reject");
    check("hard_reject_mode", {4'b0, mode_leds}, 7'b0000001);
    pattern = 4'b1000; tick("hard_accept");

    // length-2 playback with switches cleared
    pattern = 4'b0000; #1;
    check("play2_first", {3'b0, pattern_leds}, 7'b0000001);
    tick("play2_a");
    check("play2_second", {3'b0, pattern_leds}, 7'b0001000);
    tick("play2_b");

    // guess 0001 then wrong 0100, then DONE display wraps
    pattern = 4'b0001; tick("rep_ok");
    pattern = 4'b0100; tick("rep_bad");
    check("done_mode", {4'b0, mode_leds}, 7'b0000111);
    for (int i = 0; i < 3; i++) tick("done_wrap");

    // reset in the middle of a length-2 playback
    do_reset();
    level = 0;
    pattern = 4'b0110; tick("mp_e1"); tick("mp_p1");
    pattern = 4'b0110; tick("mp_r1");
    pattern = 4'b1001; tick("mp_e2");
    check("mp_in_play", {4'b0, mode_leds}, 7'b0000010);
    rst = 1; tick("mp_reset"); rst = 0;
    check("mp_n_cleared", {dut.dpath.n_q}, 7'd0);

    // randomized play against the model
    done_cnt = 0;
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      level = $urandom_range(0, 1);
      case (m_mode)
        3'b001:  pattern = $urandom_range(0, 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
        3'b100:  pattern = ($urandom_range(0, 9) == 0) ? 4'($urandom) : seq[pos];
        3'b111:  begin pattern = 4'($urandom); if (++done_cnt > 6) begin rst = 1; done_cnt = 0; end end
        default: pattern = 4'($urandom);
      endcase
      tick("rand");
      rst = 0;
    end

    // full 64-entry game in hard mode
    do_reset();
    level = 1;
    for (int k = 0; k < 64; k++) begin
      p = 4'(1 << $urandom_range(0, 3));
      pattern = p; tick("full_enter");
      for (int j = 0; j <= k; j++) begin pattern = 4'($urandom); tick("full_play"); end
      for (int j = 0; j <= k; j++) begin pattern = seq[j]; tick("full_rep"); end
    end
    check("full_won", {4'b0, mode_leds}, 7'b0000111);
    check("full_n", {dut.dpath.n_q}, 7'd64);
    for (int k = 0; k < 64; k++)
      check("full_mem", {3'b0, dut.dpath.mem.mem[k]}, {3'b0, seq[k]});
    for (int i = 0; i < 70; i++) tick("full_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
